// File: rtl/redirect_ctrl.sv
// redirect_ctrl: execute-stage control-flow resolution and front-end redirect
// sequencer.
//
// Each cycle in IDLE, the control-flow instruction in EX (if any) is resolved
// against the fetch-stage prediction. When the prediction was wrong, the
// controller:
//   - flushes the younger stages,
//   - issues a valid/ready redirect to fetch,
//   - stalls EX until the redirect has been accepted and a short flush window
//     (FLUSH_CYCLES) has passed.
//
// Optional build macro REDIRECT_MISALIGN_TRAP_EN adds the misalign_trap and
// trap_tval outputs. With it defined, a taken transfer whose target has bit 1
// set raises a one-cycle trap pulse instead of a redirect. Without it, such
// targets redirect like any other target.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | resolving EX instructions; a mispredict flushes and moves on
// REDIRECT | redirect_valid held with a stable redirect_pc until accepted
// FLUSH    | post-handshake IF/ID flush window, EX still stalled

module redirect_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic             br_taken,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      jal_target,
  input  logic [31:0]      jalr_target,
  input  logic [31:0]      pc_plus_4,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             ex_stall,
  output logic [CNT_W-1:0] ctrl_cnt,
  output logic [CNT_W-1:0] mispred_cnt
`ifdef REDIRECT_MISALIGN_TRAP_EN
  ,
  output logic             misalign_trap,
  output logic [31:0]      trap_tval
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0]       LP_FLUSH   = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_redirect_valid;
  logic [31:0]      r_redirect_pc;
  logic [3:0]       r_flush_cnt;
  logic [CNT_W-1:0] r_ctrl_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic             w_ctrl_insn;
  logic             w_resolve;
  logic             w_act_taken;
  logic [31:0]      w_act_tgt;
  logic [31:0]      w_next_pc;
  logic             w_mispredict_raw;
  logic             w_mispredict;
  logic             w_trap;
  logic             w_handshake;
  logic             w_flush_if_id;
  logic             w_flush_id_ex;
  logic             w_ex_stall;

  // Resolve the EX instruction: actual direction/target, next PC, mispredict.
  // Reset gates resolution so the outputs read zero while reset is held.
  always_comb begin
    w_ctrl_insn = is_jal | is_jalr | is_branch;
    w_resolve   = ex_valid & w_ctrl_insn & (r_state == S_IDLE) & ~rst;
    w_act_taken = is_jal | is_jalr | (is_branch & br_taken);
    if (is_jal) begin
      w_act_tgt = jal_target;
    end else if (is_jalr) begin
      w_act_tgt = jalr_target;
    end else begin
      w_act_tgt = branch_target;
    end
    // JALR bit 0 was already cleared by the target calculator; pass it through.
    w_next_pc        = w_act_taken ? w_act_tgt : pc_plus_4;
    w_mispredict_raw = (w_act_taken != pred_taken) |
                       (w_act_taken & pred_taken & (w_act_tgt != pred_target));
`ifdef REDIRECT_MISALIGN_TRAP_EN
    w_trap = w_resolve & w_act_taken & w_act_tgt[1];
`else
    w_trap = 1'b0;
`endif
    // A misaligned-target trap pre-empts the redirect.
    w_mispredict = w_resolve & w_mispredict_raw & ~w_trap;
  end

  assign w_handshake = (r_state == S_REDIRECT) & r_redirect_valid & redirect_ready;

  // Next-state and flush/stall decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_ex_stall    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mispredict) begin
          w_flush_if_id = 1'b1;
          w_flush_id_ex = 1'b1;
          w_state_nxt   = S_REDIRECT;
        end
        if (w_trap) begin
          w_flush_id_ex = 1'b1;
        end
      end
      S_REDIRECT: begin
        w_flush_if_id = 1'b1;
        w_ex_stall    = 1'b1;
        if (w_handshake) begin
          w_state_nxt = (LP_FLUSH == 4'd0) ? S_IDLE : S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_flush_if_id = 1'b1;
        w_ex_stall    = 1'b1;
        if (r_flush_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirect request: raised the cycle after detection, held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
    end else begin
      if (w_mispredict) begin
        r_redirect_valid <= 1'b1;
        r_redirect_pc    <= w_next_pc;
      end else if (w_handshake) begin
        r_redirect_valid <= 1'b0;
      end
    end
  end

  // Flush-window down-counter, loaded on the redirect handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= 4'd0;
    end else begin
      if (w_handshake) begin
        r_flush_cnt <= LP_FLUSH;
      end else if ((r_state == S_FLUSH) && (r_flush_cnt != 4'd0)) begin
        r_flush_cnt <= r_flush_cnt - 4'd1;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl_cnt    <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_resolve && (r_ctrl_cnt != LP_CNT_MAX)) begin
        r_ctrl_cnt <= r_ctrl_cnt + 1'b1;
      end
      if (w_mispredict && (r_mispred_cnt != LP_CNT_MAX)) begin
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
    end
  end

`ifdef REDIRECT_MISALIGN_TRAP_EN
  logic        r_misalign_trap;
  logic [31:0] r_trap_tval;

  // One-cycle trap pulse with the offending target captured for the handler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign_trap <= 1'b0;
      r_trap_tval     <= 32'd0;
    end else begin
      r_misalign_trap <= w_trap;
      if (w_trap) begin
        r_trap_tval <= w_act_tgt;
      end
    end
  end

  assign misalign_trap = r_misalign_trap;
  assign trap_tval     = r_trap_tval;
`endif

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush_if_id    = w_flush_if_id;
  assign flush_id_ex    = w_flush_id_ex;
  assign ex_stall       = w_ex_stall;
  assign ctrl_cnt       = r_ctrl_cnt;
  assign mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Testbench for redirect_ctrl: table of resolution vectors plus hand-written
// sequences for backpressure, reset during a redirect, counter saturation and
// the optional misaligned-target trap.
module tb_redirect_ctrl;

  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, is_branch, is_jal, is_jalr, br_taken, pred_taken;
  logic [31:0]   pred_target, branch_target, jal_target, jalr_target, pc_plus_4;
  logic          redirect_ready;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          flush_if_id, flush_id_ex, ex_stall;
  logic [CW-1:0] ctrl_cnt, mispred_cnt;
`ifdef REDIRECT_MISALIGN_TRAP_EN
  logic          misalign_trap;
  logic [31:0]   trap_tval;
`endif

  always #5 clk = ~clk;

  redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .br_taken(br_taken),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .branch_target(branch_target), .jal_target(jal_target),
    .jalr_target(jalr_target), .pc_plus_4(pc_plus_4),
    .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .ex_stall(ex_stall),
    .ctrl_cnt(ctrl_cnt), .mispred_cnt(mispred_cnt)
`ifdef REDIRECT_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap), .trap_tval(trap_tval)
`endif
  );

  typedef struct packed {
    logic        ev, br, jal, jalr, tk, pt;
    logic [31:0] ptg, btg, jtg, rtg, p4;
    logic        mis;
    logic [31:0] epc;
  } vec_t;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          exp_ctrl = 0;
  int          exp_mis  = 0;
  logic [31:0] sb[$];
  vec_t        vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ev, br, jal, jalr, tk, pt,
                              input logic [31:0] ptg, btg, jtg, rtg, p4,
                              input logic mis, input logic [31:0] epc);
    vec_t v;
    v = '{ev:ev, br:br, jal:jal, jalr:jalr, tk:tk, pt:pt, ptg:ptg, btg:btg,
          jtg:jtg, rtg:rtg, p4:p4, mis:mis, epc:epc};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ex_valid = v.ev; is_branch = v.br; is_jal = v.jal; is_jalr = v.jalr;
    br_taken = v.tk; pred_taken = v.pt; pred_target = v.ptg;
    branch_target = v.btg; jal_target = v.jtg; jalr_target = v.rtg;
    pc_plus_4 = v.p4;
  endtask

  task automatic drive_idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic count(input vec_t v, input logic mis);
    if (v.ev && (v.br || v.jal || v.jalr)) exp_ctrl = (exp_ctrl < MAX) ? exp_ctrl + 1 : MAX;
    if (mis) exp_mis = (exp_mis < MAX) ? exp_mis + 1 : MAX;
  endtask

  // Resolve one vector with redirect_ready high and walk the full penalty.
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk); #1; drive(v);
    @(negedge clk);
    chk({tag, "_det_flush_id_ex"}, 32'(flush_id_ex), 32'(v.mis));
    chk({tag, "_det_flush_if_id"}, 32'(flush_if_id), 32'(v.mis));
    chk({tag, "_det_stall"}, 32'(ex_stall), 0);
    chk({tag, "_det_valid"}, 32'(redirect_valid), 0);
    count(v, v.mis);
    if (v.mis) sb.push_back(v.epc);
    @(posedge clk); #1; drive_idle();
    if (v.mis) begin
      @(negedge clk);
      chk({tag, "_rd_valid"}, 32'(redirect_valid), 1);
      chk({tag, "_rd_pc"}, redirect_pc, v.epc);
      chk({tag, "_rd_stall"}, 32'(ex_stall), 1);
      chk({tag, "_rd_flush_if_id"}, 32'(flush_if_id), 1);
      chk({tag, "_rd_flush_id_ex"}, 32'(flush_id_ex), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_fl_valid"}, 32'(redirect_valid), 0);
      chk({tag, "_fl_stall"}, 32'(ex_stall), 1);
      chk({tag, "_fl_flush_if_id"}, 32'(flush_if_id), 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_idle_stall"}, 32'(ex_stall), 0);
    chk({tag, "_idle_flush_if_id"}, 32'(flush_if_id), 0);
    chk({tag, "_ctrl_cnt"}, 32'(ctrl_cnt), 32'(exp_ctrl));
    chk({tag, "_mispred_cnt"}, 32'(mispred_cnt), 32'(exp_mis));
  endtask

  // Scoreboard: every accepted redirect must match the oldest expected PC.
  always @(negedge clk) begin
    if (!rst && redirect_valid && redirect_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL hs_unexpected: got redirect 0x%08h expected none", redirect_pc);
      end else begin
        chk("hs_redirect_pc", redirect_pc, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t nz;
    //            ev br jl jr tk pt ptg    btg    jtg    rtg    p4     mis epc
    vecs[0]  = mk(1, 1, 0, 0, 1, 1, 'h100, 'h100, 'h0,   'h0,   'h104, 0, 'h0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 1, 'h200, 'h200, 'h0,   'h0,   'h204, 1, 'h204);
    vecs[2]  = mk(1, 1, 1, 0, 1, 1, 'h80,  'h80,  'h40,  'h0,   'h44,  1, 'h40);
    vecs[3]  = mk(1, 1, 0, 0, 1, 0, 'h0,   'h300, 'h0,   'h0,   'h304, 1, 'h300);
    vecs[4]  = mk(1, 1, 0, 0, 1, 1, 'h404, 'h400, 'h0,   'h0,   'h3fc, 1, 'h400);
    vecs[5]  = mk(1, 1, 0, 0, 0, 0, 'h0,   'h500, 'h0,   'h0,   'h508, 0, 'h0);
    vecs[6]  = mk(1, 1, 0, 1, 1, 1, 'h600, 'h700, 'h0,   'h600, 'h604, 0, 'h0);
    vecs[7]  = mk(1, 0, 1, 1, 0, 1, 'h900, 'h0,   'h800, 'h900, 'h7fc, 1, 'h800);
    vecs[8]  = mk(0, 1, 0, 0, 0, 1, 'h200, 'h200, 'h0,   'h0,   'h804, 0, 'h0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 1, 'h900, 'h0,   'h0,   'h0,   'h904, 0, 'h0);
    vecs[10] = mk(1, 0, 0, 1, 0, 0, 'h0,   'h0,   'h0,   'ha01, 'ha04, 1, 'ha01);
    vecs[11] = mk(1, 0, 1, 0, 0, 1, 'hb00, 'h0,   'hb00, 'h0,   'hb04, 0, 'h0);

    rst = 1'b1;
    redirect_ready = 1'b1;
    drive_idle();
    #2;
    chk("rst_valid", 32'(redirect_valid), 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_stall", 32'(ex_stall), 0);
    chk("rst_flush", 32'({flush_if_id, flush_id_ex}), 0);
    chk("rst_cnts", 32'({ctrl_cnt, mispred_cnt}), 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Backpressure: JALR redirect held for five not-ready cycles.
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    drive(mk(1, 0, 0, 1, 0, 0, 'h0, 'h0, 'h0, 'h8000_0010, 'h1000, 1, 'h8000_0010));
    @(negedge clk);
    chk("bp_det_flush_id_ex", 32'(flush_id_ex), 1);
    exp_ctrl++; exp_mis++;
    sb.push_back(32'h8000_0010);
    nz = mk(1, 1, 0, 0, 0, 1, 'h0, 'h0, 'h0, 'h0, 'h2000, 0, 'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      redirect_ready = (i == 5);
      drive(nz);
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i), 32'(redirect_valid), 1);
      chk($sformatf("bp_pc_%0d", i), redirect_pc, 32'h8000_0010);
      chk($sformatf("bp_stall_%0d", i), 32'(ex_stall), 1);
      chk($sformatf("bp_ctrl_%0d", i), 32'(ctrl_cnt), 32'(exp_ctrl));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_fl_valid", 32'(redirect_valid), 0);
    chk("bp_fl_stall", 32'(ex_stall), 1);
    @(posedge clk); #1; drive_idle();
    @(negedge clk);
    chk("bp_idle_stall", 32'(ex_stall), 0);
    chk("bp_ctrl_cnt", 32'(ctrl_cnt), 32'(exp_ctrl));
    chk("bp_mispred_cnt", 32'(mispred_cnt), 32'(exp_mis));

    // Reset while a redirect is pending and not accepted.
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    drive(vecs[1]);
    @(negedge clk);
    chk("rr_det_flush", 32'(flush_id_ex), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_pre_valid", 32'(redirect_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("rr_valid", 32'(redirect_valid), 0);
    chk("rr_pc", redirect_pc, 0);
    chk("rr_flush_if_id", 32'(flush_if_id), 0);
    chk("rr_flush_id_ex", 32'(flush_id_ex), 0);
    chk("rr_stall", 32'(ex_stall), 0);
    chk("rr_cnts", 32'({ctrl_cnt, mispred_cnt}), 0);
    exp_ctrl = 0; exp_mis = 0;
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_post_stall", 32'(ex_stall), 0);
    chk("rr_post_valid", 32'(redirect_valid), 0);
    apply(vecs[0], "rr_v0");

`ifdef REDIRECT_MISALIGN_TRAP_EN
    // Misaligned JAL target traps instead of redirecting.
    @(posedge clk); #1;
    drive(mk(1, 0, 1, 0, 0, 0, 'h0, 'h0, 'h102, 'h0, 'h200, 0, 'h0));
    @(negedge clk);
    chk("tr_det_flush_id_ex", 32'(flush_id_ex), 1);
    chk("tr_det_trap", 32'(misalign_trap), 0);
    exp_ctrl++;
    @(posedge clk); #1; drive_idle();
    @(negedge clk);
    chk("tr_trap", 32'(misalign_trap), 1);
    chk("tr_tval", trap_tval, 32'h102);
    chk("tr_valid", 32'(redirect_valid), 0);
    chk("tr_stall", 32'(ex_stall), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tr_trap_end", 32'(misalign_trap), 0);
    chk("tr_valid_end", 32'(redirect_valid), 0);
    chk("tr_ctrl_cnt", 32'(ctrl_cnt), 32'(exp_ctrl));
    chk("tr_mispred_cnt", 32'(mispred_cnt), 32'(exp_mis));
`else
    apply(mk(1, 0, 1, 0, 0, 0, 'h0, 'h0, 'h102, 'h0, 'h200, 1, 'h102), "mis_jal");
`endif

    // Drive both counters into saturation.
    for (int i = 0; i < 17; i++) apply(vecs[1], $sformatf("sat%0d", i));
    apply(vecs[0], "sat_final");
    chk("sat_ctrl_max", 32'(ctrl_cnt), MAX);
    chk("sat_mis_max", 32'(mispred_cnt), MAX);

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
Name: redirect_ctrl

Overview:
- Execute-stage control-flow resolution and front-end redirect sequencer.
- Consumes the candidate targets from the EX target calculator (branch, JAL, JALR, PC+4), the branch comparator outcome and the fetch-stage prediction.
- Decides the architecturally correct next PC and detects mispredicts.
- On a mispredict, issues a valid/ready redirect to fetch, flushes younger pipeline stages and stalls EX until the front end has accepted the new PC.

Parameters:
- FLUSH_CYCLES, 1, cycles of IF/ID flush held after the redirect handshake completes (0..15); covers in-flight stale fetches.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- ex_valid  input  1  valid instruction in EX this cycle
- is_branch  input  1  EX instruction is a conditional branch
- is_jal  input  1  EX instruction is JAL
- is_jalr  input  1  EX instruction is JALR
- br_taken  input  1  branch comparator result; meaningful only with is_branch
- pred_taken  input  1  fetch prediction carried down the pipe
- pred_target  input  32  predicted target carried down the pipe
- branch_target  input  32  PC+imm (B-type)
- jal_target  input  32  PC+imm (J-type)
- jalr_target  input  32  (rs1+imm)&~1
- pc_plus_4  input  32  fall-through / link PC
- redirect_ready  input  1  fetch accepts redirect
- redirect_valid  output  1  redirect request to fetch
- redirect_pc  output  32  new fetch PC, stable while redirect_valid=1
- flush_if_id  output  1  kill IF/ID contents
- flush_id_ex  output  1  kill ID/EX contents
- ex_stall  output  1  hold EX and all upstream stages
- ctrl_cnt  output  CNT_W  resolved control-flow instructions, saturating
- mispred_cnt  output  CNT_W  mispredicts, saturating

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; redirect_valid=0, redirect_pc=0, flush_if_id=0, flush_id_ex=0, ex_stall=0, both counters=0. Reset mid-operation abandons any pending redirect without a handshake.
- Resolution (combinational, IDLE only), performed when ex_valid=1 and any is_* is set:
  - Priority when multiple is_* are set: is_jal > is_jalr > is_branch.
  - act_taken = is_jal | is_jalr | (is_branch & br_taken).
  - act_tgt = jal_target / jalr_target / branch_target, selected by the priority above.
  - next_pc = act_taken ? act_tgt : pc_plus_4.
  - mispredict = (act_taken != pred_taken) | (act_taken & pred_taken & act_tgt != pred_target).
- Non-control instruction, or ex_valid=0: no action and no count.
- State machine:
  - IDLE:
    - ctrl_cnt increments on every resolution.
    - On mispredict in the same cycle:
      - flush_if_id=1 and flush_id_ex=1 (combinational).
      - mispred_cnt increments.
      - redirect_pc<=next_pc.
      - Go to REDIRECT.
    - Correct prediction: stay in IDLE and assert nothing.
  - REDIRECT:
    - redirect_valid=1 (registered, first asserted the cycle after detection), ex_stall=1, flush_if_id=1.
    - redirect_pc held constant; redirect_valid must not drop before the handshake.
    - When redirect_valid & redirect_ready: go to FLUSH with count=FLUSH_CYCLES, or to IDLE if FLUSH_CYCLES=0.
  - FLUSH:
    - redirect_valid=0, flush_if_id=1, ex_stall=1.
    - Count decrements each cycle; go to IDLE on the cycle count reaches 1.
- ex_valid and is_* are ignored outside IDLE; no resolution and no counting.
- Minimum mispredict penalty with redirect_ready tied high and FLUSH_CYCLES=1:
  - detect cycle, then 1 REDIRECT cycle, then 1 FLUSH cycle.
  - Back in IDLE on the 4th cycle.
- Counters stick at all-ones and do not wrap.
- next_pc arithmetic is inherited unchanged. JALR bit 0 is already cleared upstream and must not be re-masked.

Optional Feature:
- Macro: REDIRECT_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_trap (1 bit) and output trap_tval (32 bits).
  - In IDLE, when act_taken=1 and act_tgt[1]=1, the controller does not issue a redirect and does not count a mispredict. Instead:
    - misalign_trap pulses high for 1 cycle, registered.
    - trap_tval is loaded with act_tgt.
    - flush_id_ex=1 in the detection cycle.
  - ctrl_cnt still increments.
  - The trap takes priority over mispredict.
- Undefined: the ports are absent and misaligned targets redirect normally.

Test Plan:
- Correct prediction: is_branch=1, br_taken=1, pred_taken=1, branch_target=pred_target=0x100 -> no redirect, no flush; ctrl_cnt=1, mispred_cnt=0.
- Not-taken mispredict: is_branch=1, br_taken=0, pred_taken=1, pc_plus_4=0x204, redirect_ready=1 ->
  - detect cycle: flush_if_id=flush_id_ex=1;
  - next cycle: redirect_valid=1, redirect_pc=0x204;
  - then 1 FLUSH cycle; IDLE on the 4th cycle; mispred_cnt=1.
- Backpressure: JALR with jalr_target=0x8000_0010, pred_taken=0, redirect_ready=0 for 5 cycles then 1 -> redirect_valid and redirect_pc=0x8000_0010 held 6 cycles; ex_stall=1 throughout; is_* pulses during the stall are not counted.
- Priority: is_jal=1 and is_branch=1 together, jal_target=0x40, branch_target=0x80, pred_target=0x80, pred_taken=1 -> mispredict, redirect_pc=0x40.
- Reset mid-REDIRECT: assert rst while redirect_valid=1 -> all outputs 0 immediately, with no clock edge needed; state IDLE after rst deasserts.
- With REDIRECT_MISALIGN_TRAP_EN defined: JAL with jal_target=0x102, pred_taken=0 -> misalign_trap=1 for one cycle, trap_tval=0x102, no redirect_valid, mispred_cnt unchanged.
